// File: rtl/spi_cfg_master.sv
// SPI mode-0 master writing 16-bit config frames {1'b1, addr[6:0], data[7:0]} for two round-robin requesters.
// Latency: frame occupies 34*CLK_DIV cycles after the accept; done pulses at accept+1+33*CLK_DIV.
// Backpressure: reqN_ready is high only in IDLE for the granted requester; no queuing beyond the active frame.
module spi_cfg_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  edge_q, edge_d;
    logic [15:0] shreg_q, shreg_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic        sclk_q, sclk_d;
    logic        ncs_q, ncs_d;
    logic        copi_q, copi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic        gnt0, gnt1, idle_ok;
    logic [15:0] frame;

    // last_q=1 means req1 was granted last, so a tie goes to req0 (the reset state).
    assign gnt1       = req1_valid & (~req0_valid | ~last_q);
    assign gnt0       = req0_valid & ~gnt1;
    assign idle_ok    = (state_q == IDLE) & rst_n;
    assign req0_ready = idle_ok & gnt0;
    assign req1_ready = idle_ok & gnt1;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        shreg_d   = shreg_q;
        id_d      = id_q;
        last_d    = last_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        copi_d    = copi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        frame     = 16'h0000;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    frame   = req1_ready ? {1'b1, req1_addr, req1_data}
                                         : {1'b1, req0_addr, req0_data};
                    state_d = SETUP;
                    div_d   = 8'd0;
                    edge_d  = 5'd0;
                    shreg_d = {frame[14:0], 1'b0};
                    copi_d  = frame[15];
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 8'd0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // Last falling edge parks copi low and ends the shift phase.
                        if (edge_q == 5'd15) begin
                            copi_d  = 1'b0;
                            state_d = HOLD;
                        end else begin
                            copi_d  = shreg_q[15];
                            shreg_d = {shreg_q[14:0], 1'b0};
                            edge_d  = edge_q + 5'd1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d     = 8'd0;
                    ncs_d     = 1'b1;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    state_d   = GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            edge_q    <= 5'd0;
            shreg_q   <= 16'h0000;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            shreg_q   <= shreg_d;
            id_q      <= id_d;
            last_q    <= last_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            copi_q    <= copi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign sclk    = sclk_q;
    assign ncs     = ncs_q;
    assign copi    = copi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: one instance at CLK_DIV=4, one at CLK_DIV=1, selected by use1.
module tb_spi_cfg_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, use1;
    logic [6:0] a0, a1;
    logic [7:0] d0, d1;

    logic r0_4, r1_4, sclk4, ncs4, copi4, busy4, done4, did4;
    logic r0_1, r1_1, sclk1, ncs1, copi1, busy1, done1, did1;
    logic m_rdy0, m_rdy1, m_sclk, m_ncs, m_copi, m_busy, m_done, m_did;

    int cyc = 0;
    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_cfg_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0 & ~use1), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_4),
        .req1_valid(v1 & ~use1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_4),
        .sclk(sclk4), .ncs(ncs4), .copi(copi4), .busy(busy4), .done(done4), .done_id(did4)
    );

    spi_cfg_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0 & use1), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_1),
        .req1_valid(v1 & use1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_1),
        .sclk(sclk1), .ncs(ncs1), .copi(copi1), .busy(busy1), .done(done1), .done_id(did1)
    );

    assign m_rdy0 = use1 ? r0_1  : r0_4;
    assign m_rdy1 = use1 ? r1_1  : r1_4;
    assign m_sclk = use1 ? sclk1 : sclk4;
    assign m_ncs  = use1 ? ncs1  : ncs4;
    assign m_copi = use1 ? copi1 : copi4;
    assign m_busy = use1 ? busy1 : busy4;
    assign m_done = use1 ? done1 : done4;
    assign m_did  = use1 ? did1  : did4;

    typedef struct {
        logic [15:0] bits;
        int nrise, first_rise, ntog, first_tog, last_tog;
        int ndone, done_at;
        logic did;
        int ncs_first, ncs_last, ncs_cnt, idle_at, rdy_busy, rdy0_seen;
    } obs_t;

    // Reference: the frame a requester expects on the wire.
    function automatic logic [15:0] frame_of(input logic [6:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    // Reference round-robin: single valid wins; on a tie the one not granted last wins.
    function automatic logic pick(input logic q0, input logic q1, input logic last);
        if (q0 && q1) return ~last;
        return q1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_accept(output bit got, output logic id, output int t);
        got = 1'b0; id = 1'b0; t = 0;
        #1;
        for (int i = 0; i < 400; i++) begin
            if (m_rdy0 === 1'b1 || m_rdy1 === 1'b1) begin
                got = 1'b1; id = m_rdy1; t = cyc;
                return;
            end
            step();
        end
    endtask

    // Watches one full frame starting from the accept cycle; k counts cycles after the accept.
    task automatic observe(input int d, output obs_t o);
        logic ps;
        o = '{default: 0};
        ps = m_sclk;
        for (int k = 1; k <= 34 * d + 1; k++) begin
            step();
            if (m_sclk !== ps) begin
                o.ntog++;
                if (o.first_tog == 0) o.first_tog = k;
                o.last_tog = k;
            end
            if (m_sclk === 1'b1 && ps === 1'b0) begin
                o.bits = {o.bits[14:0], m_copi};
                o.nrise++;
                if (o.first_rise == 0) o.first_rise = k;
            end
            ps = m_sclk;
            if (m_done === 1'b1) begin o.ndone++; o.done_at = k; o.did = m_did; end
            if (m_ncs === 1'b0) begin
                o.ncs_cnt++;
                if (o.ncs_first == 0) o.ncs_first = k;
                o.ncs_last = k;
            end
            if (m_busy === 1'b0 && o.idle_at == 0) o.idle_at = k;
            if ((m_rdy0 === 1'b1 || m_rdy1 === 1'b1) && m_busy === 1'b1) o.rdy_busy++;
            if (m_rdy0 === 1'b1) o.rdy0_seen++;
        end
    endtask

    task automatic test_reset();
        v0 = 0; v1 = 0; use1 = 0;
        rst_n = 1'b0;
        step(); step();
        vec++; if ({sclk4, ncs4, copi4, busy4, done4, did4} !== 6'b010000) begin
            miss++; $display("FAIL reset_outs got=%b exp=010000", {sclk4, ncs4, copi4, busy4, done4, did4}); end
        vec++; if ({r0_4, r1_4} !== 2'b00) begin
            miss++; $display("FAIL reset_ready got=%b exp=00", {r0_4, r1_4}); end
        vec++; if ({sclk1, ncs1, copi1, busy1} !== 4'b0100) begin
            miss++; $display("FAIL reset_d1 got=%b exp=0100", {sclk1, ncs1, copi1, busy1}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit got; logic id; int t; obs_t o;
        use1 = 0; v0 = 1; a0 = 7'h00; d0 = 8'hA5;
        wait_accept(got, id, t);
        vec++; if (got !== 1'b1 || id !== 1'b0) begin
            miss++; $display("FAIL single_accept got=%b id=%b exp got=1 id=0", got, id); end
        observe(4, o);
        v0 = 0;
        vec++; if (o.bits !== frame_of(7'h00, 8'hA5) || o.nrise != 16) begin
            miss++; $display("FAIL single_bits got=%h rises=%0d exp=%h rises=16", o.bits, o.nrise, frame_of(7'h00, 8'hA5)); end
        vec++; if (o.first_rise != 1 + 4) begin
            miss++; $display("FAIL single_first_rise got=%0d exp=%0d", o.first_rise, 5); end
        vec++; if (o.ncs_first != 1 || o.ncs_last != 33 * 4 || o.ncs_cnt != 33 * 4) begin
            miss++; $display("FAIL single_ncs got=%0d..%0d cnt=%0d exp=1..132 cnt=132", o.ncs_first, o.ncs_last, o.ncs_cnt); end
        vec++; if (o.ndone != 1 || o.done_at != 1 + 33 * 4 || o.did !== 1'b0) begin
            miss++; $display("FAIL single_done got n=%0d at=%0d id=%b exp n=1 at=133 id=0", o.ndone, o.done_at, o.did); end
        vec++; if (o.idle_at != 1 + 34 * 4) begin
            miss++; $display("FAIL single_idle got=%0d exp=137", o.idle_at); end
    endtask

    task automatic test_arbitration();
        bit got; logic id, exp_id, last; int t; obs_t o; logic [15:0] exp;
        use1 = 0;
        do_reset();
        last = 1'b1;
        v0 = 1; v1 = 1;
        a0 = 7'($urandom); d0 = 8'($urandom); a1 = 7'($urandom); d1 = 8'($urandom);
        for (int n = 0; n < 3; n++) begin
            wait_accept(got, id, t);
            exp_id = pick(1'b1, 1'b1, last);
            vec++; if (got !== 1'b1 || id !== exp_id) begin
                miss++; $display("FAIL arb_grant%0d got=%b id=%b exp id=%b", n, got, id, exp_id); end
            vec++; if ((m_rdy0 & m_rdy1) !== 1'b0) begin
                miss++; $display("FAIL arb_both_ready%0d got=%b%b exp one-hot", n, m_rdy0, m_rdy1); end
            exp = exp_id ? frame_of(a1, d1) : frame_of(a0, d0);
            last = exp_id;
            observe(4, o);
            vec++; if (o.bits !== exp || o.did !== exp_id || o.ndone != 1) begin
                miss++; $display("FAIL arb_frame%0d got=%h id=%b n=%0d exp=%h id=%b", n, o.bits, o.did, o.ndone, exp, exp_id); end
            if (exp_id) begin a1 = 7'($urandom); d1 = 8'($urandom); end
            else begin a0 = 7'($urandom); d0 = 8'($urandom); end
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_back_to_back();
        bit got; logic id; int t, tp; obs_t o; logic [15:0] exp;
        use1 = 0; v0 = 0; v1 = 1;
        a1 = 7'($urandom); d1 = 8'($urandom);
        tp = 0;
        for (int n = 0; n < 3; n++) begin
            wait_accept(got, id, t);
            vec++; if (got !== 1'b1 || id !== 1'b1) begin
                miss++; $display("FAIL b2b_grant%0d got=%b id=%b exp id=1", n, got, id); end
            if (n > 0) begin
                vec++; if (t - tp != 34 * 4 + 1) begin
                    miss++; $display("FAIL b2b_spacing%0d got=%0d exp=137", n, t - tp); end
            end
            tp = t;
            exp = frame_of(a1, d1);
            observe(4, o);
            vec++; if (o.bits !== exp || o.rdy_busy != 0 || o.rdy0_seen != 0) begin
                miss++; $display("FAIL b2b_frame%0d got=%h rdy_busy=%0d rdy0=%0d exp=%h 0 0", n, o.bits, o.rdy_busy, o.rdy0_seen, exp); end
            a1 = 7'($urandom); d1 = 8'($urandom);
        end
        v1 = 0;
    endtask

    task automatic test_reset_mid();
        bit got; logic id; int t, nr, nd, nb; logic ps; obs_t o;
        use1 = 0; v0 = 1; v1 = 0;
        a0 = 7'($urandom); d0 = 8'($urandom);
        wait_accept(got, id, t);
        nr = 0; ps = 1'b0;
        for (int i = 0; i < 200 && nr < 5; i++) begin
            step();
            if (m_sclk === 1'b1 && ps === 1'b0) nr++;
            ps = m_sclk;
        end
        v0 = 0;
        vec++; if (nr != 5) begin
            miss++; $display("FAIL rstmid_reach got=%0d rises exp=5", nr); end
        rst_n = 1'b0;
        step();
        vec++; if ({ncs4, sclk4, copi4, busy4, done4} !== 5'b10000) begin
            miss++; $display("FAIL rstmid_outs got=%b exp=10000", {ncs4, sclk4, copi4, busy4, done4}); end
        rst_n = 1'b1;
        nd = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_done === 1'b1) nd++;
            if (m_busy === 1'b1) nb++;
        end
        vec++; if (nd != 0 || nb != 0) begin
            miss++; $display("FAIL rstmid_quiet got done=%0d busy=%0d exp 0 0", nd, nb); end
        v0 = 1; v1 = 1;
        wait_accept(got, id, t);
        vec++; if (got !== 1'b1 || id !== pick(1'b1, 1'b1, 1'b1) || m_rdy1 !== 1'b0) begin
            miss++; $display("FAIL rstmid_rr got=%b id=%b rdy1=%b exp id=0 rdy1=0", got, id, m_rdy1); end
        observe(4, o);
        v0 = 0; v1 = 0;
    endtask

    task automatic test_drop_early();
        bit got; logic id; int t, r1seen, late_busy, nd; logic ldid;
        use1 = 0; v0 = 1; v1 = 0;
        a0 = 7'($urandom); d0 = 8'($urandom); a1 = 7'($urandom); d1 = 8'($urandom);
        wait_accept(got, id, t);
        vec++; if (got !== 1'b1 || id !== 1'b0) begin
            miss++; $display("FAIL drop_accept got=%b id=%b exp id=0", got, id); end
        r1seen = 0; late_busy = 0; nd = 0; ldid = 1'b0;
        for (int k = 1; k <= 34 * 4 + 60; k++) begin
            step();
            if (k == 1) v0 = 0;
            if (k == 20) v1 = 1;
            if (k == 30) v1 = 0;
            if (m_rdy1 === 1'b1) r1seen++;
            if (m_done === 1'b1) begin nd++; ldid = m_did; end
            if (k > 34 * 4 && m_busy === 1'b1) late_busy++;
        end
        vec++; if (r1seen != 0 || late_busy != 0) begin
            miss++; $display("FAIL drop_no_grant got rdy1=%0d late_busy=%0d exp 0 0", r1seen, late_busy); end
        vec++; if (nd != 1 || ldid !== 1'b0) begin
            miss++; $display("FAIL drop_done got n=%0d id=%b exp n=1 id=0", nd, ldid); end
    endtask

    task automatic test_div1();
        bit got; logic id; int t, t2; obs_t o; logic [15:0] exp;
        use1 = 1; v0 = 0; v1 = 0;
        do_reset();
        v0 = 1; a0 = 7'h04; d0 = 8'h80;
        wait_accept(got, id, t);
        vec++; if (got !== 1'b1 || id !== 1'b0) begin
            miss++; $display("FAIL div1_accept got=%b id=%b exp id=0", got, id); end
        observe(1, o);
        vec++; if (o.bits !== frame_of(7'h04, 8'h80) || o.nrise != 16) begin
            miss++; $display("FAIL div1_bits got=%h rises=%0d exp=%h rises=16", o.bits, o.nrise, frame_of(7'h04, 8'h80)); end
        vec++; if (o.ntog != 32 || o.first_tog != 2 || o.last_tog != 33) begin
            miss++; $display("FAIL div1_toggle got n=%0d %0d..%0d exp n=32 2..33", o.ntog, o.first_tog, o.last_tog); end
        vec++; if (o.done_at != 34 || o.idle_at != 35) begin
            miss++; $display("FAIL div1_timing got done=%0d idle=%0d exp 34 35", o.done_at, o.idle_at); end
        a0 = 7'($urandom); d0 = 8'($urandom);
        exp = frame_of(a0, d0);
        wait_accept(got, id, t2);
        vec++; if (got !== 1'b1 || t2 - t != 35) begin
            miss++; $display("FAIL div1_next got=%b spacing=%0d exp spacing=35", got, t2 - t); end
        observe(1, o);
        v0 = 0;
        vec++; if (o.bits !== exp) begin
            miss++; $display("FAIL div1_second got=%h exp=%h", o.bits, exp); end
    endtask

    task automatic test_random();
        bit got; logic id, exp_id, last; int t; obs_t o; logic [15:0] exp; logic q0, q1;
        use1 = 1;
        last = 1'b0;
        for (int n = 0; n < 8; n++) begin
            q0 = 1'($urandom); q1 = 1'($urandom);
            if (!q0 && !q1) q1 = 1'b1;
            a0 = 7'($urandom); d0 = 8'($urandom); a1 = 7'($urandom); d1 = 8'($urandom);
            v0 = q0; v1 = q1;
            exp_id = pick(q0, q1, last);
            exp = exp_id ? frame_of(a1, d1) : frame_of(a0, d0);
            wait_accept(got, id, t);
            vec++; if (got !== 1'b1 || id !== exp_id) begin
                miss++; $display("FAIL rand_grant%0d v=%b%b got=%b id=%b exp id=%b", n, q1, q0, got, id, exp_id); end
            last = exp_id;
            observe(1, o);
            v0 = 0; v1 = 0;
            vec++; if (o.bits !== exp || o.did !== exp_id || o.ndone != 1) begin
                miss++; $display("FAIL rand_frame%0d got=%h id=%b n=%0d exp=%h id=%b", n, o.bits, o.did, o.ndone, exp, exp_id); end
        end
    endtask

    initial begin
        rst_n = 1'b0; use1 = 1'b0;
        v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        test_reset();
        test_single();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_drop_early();
        test_div1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
